// File: rtl/coeff_fir_mac_pkg.sv
// Shared constants and types for the serial FIR MAC and its coefficient array.
//   NTAPS / AW  : tap count and coefficient address width
//   DW / CW     : signed sample and coefficient widths
//   PW / ACC_W  : product width and overflow-free accumulator width
package coeff_fir_mac_pkg;

    localparam int unsigned NTAPS = 71;
    localparam int unsigned AW    = 7;
    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = 8;
    localparam int unsigned PW    = DW + CW;
    localparam int unsigned ACC_W = DW + CW + 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Circular-buffer index of the sample k taps older than the one at wr_ptr.
    function automatic logic [AW-1:0] tap_index(input logic [AW-1:0] wr_ptr,
                                                input logic [AW-1:0] k);
        logic [AW:0]   wrapped;
        logic [AW-1:0] idx;
        wrapped = {1'b0, wr_ptr} + (AW+1)'(NTAPS) - {1'b0, k};
        if (wr_ptr >= k) begin
            idx = wr_ptr - k;
        end else begin
            idx = AW'(wrapped);
        end
        return idx;
    endfunction

endpackage

// File: rtl/coeff_fir_mac_delay.sv
// Circular sample history for the FIR: one write slot per accepted sample,
// combinational tap read relative to the newest sample.
//   wr_en/wr_data : store a sample at the current write pointer
//   advance       : move the write pointer on (after the output handshake)
//   tap/tap_data  : read the sample 'tap' positions older than the newest
module fir_delay_line
    import coeff_fir_mac_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          advance,
    input  logic [AW-1:0] tap,
    output logic [DW-1:0] tap_data
);

    logic [DW-1:0] mem [NTAPS];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_idx;

    // Sample storage and write pointer, fully cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
            end
            if (advance) begin
                wr_ptr <= (wr_ptr == AW'(NTAPS - 1)) ? '0 : wr_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        rd_idx   = tap_index(wr_ptr, tap);
        tap_data = mem[rd_idx];
    end

endmodule

// File: rtl/coeff_fir_mac.sv
// Serial multiply-accumulate FIR engine; read side of the coefficient array.
//   s_valid/s_ready/s_data : input sample handshake
//   coeff_addr/coeff_data  : combinational coefficient array read port
//   busy                   : MAC in progress, coefficient writes must wait
//   m_valid/m_ready/m_data : filtered output handshake
module coeff_fir_mac
    import coeff_fir_mac_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    output logic [AW-1:0]    coeff_addr,
    input  logic [CW-1:0]    coeff_data,
    output logic             busy,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_data
);

    state_t                   state;
    state_t                   state_nxt;
    logic [AW-1:0]            k;
    logic signed [PW-1:0]     prod;
    logic                     prod_valid;
    logic signed [ACC_W-1:0]  acc;
    logic [DW-1:0]            tap_sample;
    logic                     accept;
    logic                     out_fire;
    logic                     last_tap;

    assign accept   = (state == ST_IDLE) && s_valid;
    assign out_fire = (state == ST_OUT) && m_ready;
    assign last_tap = (k == AW'(NTAPS - 1));

    fir_delay_line u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (accept),
        .wr_data  (s_data),
        .advance  (out_fire),
        .tap      (k),
        .tap_data (tap_sample)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (s_valid)  state_nxt = ST_MAC;
            ST_MAC:   if (last_tap) state_nxt = ST_DRAIN;
            ST_DRAIN:               state_nxt = ST_OUT;
            ST_OUT:   if (m_ready)  state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; m_data is the accumulator register, frozen outside MAC/DRAIN.
    always_comb begin
        s_ready    = 1'b0;
        busy       = 1'b0;
        m_valid    = 1'b0;
        coeff_addr = '0;
        m_data     = acc;
        case (state)
            ST_IDLE:  s_ready = 1'b1;
            ST_MAC: begin
                busy       = 1'b1;
                coeff_addr = k;
            end
            ST_DRAIN: busy    = 1'b1;
            ST_OUT:   m_valid = 1'b1;
            default: ;
        endcase
    end

    // Two-stage datapath: multiply this tap, accumulate the previous product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k          <= '0;
            prod       <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        k          <= '0;
                        acc        <= '0;
                        prod_valid <= 1'b0;
                    end
                end
                ST_MAC: begin
                    prod       <= PW'($signed(tap_sample)) * PW'($signed(coeff_data));
                    prod_valid <= 1'b1;
                    if (prod_valid) begin
                        acc <= acc + ACC_W'(prod);
                    end
                    k <= last_tap ? '0 : k + 1'b1;
                end
                ST_DRAIN: begin
                    if (prod_valid) begin
                        acc <= acc + ACC_W'(prod);
                    end
                    prod_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coeff_fir_mac.sv
// Self-checking bench for coeff_fir_mac: impulse vector table, latency and
// addressing, backpressure, throughput, async reset, full scale, random data.
module tb_coeff_fir_mac;
    import coeff_fir_mac_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [DW-1:0]    s_data = '0;
    logic [AW-1:0]    coeff_addr;
    logic [CW-1:0]    coeff_data;
    logic             busy;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [ACC_W-1:0] m_data;

    int n_checks = 0;
    int n_fail   = 0;

    int     coef [NTAPS];
    longint hist [$];

    typedef struct {
        int     sample;
        longint expected;
    } vec_t;
    vec_t vec [75];

    coeff_fir_mac dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .coeff_addr (coeff_addr),
        .coeff_data (coeff_data),
        .busy       (busy),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
    );

    always #5 clk = ~clk;

    // Combinational coefficient array model.
    always_comb begin
        coeff_data = '0;
        if (coeff_addr < AW'(NTAPS)) coeff_data = CW'(coef[coeff_addr]);
    end

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_model(input int x);
        hist.push_front(longint'(x));
        if (hist.size() > NTAPS) void'(hist.pop_back());
    endtask

    function automatic longint model_y();
        longint s = 0;
        for (int i = 0; i < hist.size(); i++) s += hist[i] * longint'(coef[i]);
        return s;
    endfunction

    task automatic apply_reset();
        s_valid = 1'b0;
        m_ready = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        hist.delete();
        @(posedge clk); #1;
    endtask

    // Returns at 1ns after the accepting edge.
    task automatic send_sample(input int x);
        int t = 0;
        while (!s_ready && t < 300) begin
            @(posedge clk); #1; t++;
        end
        if (!s_ready) begin
            check("s_ready_timeout", s_ready, 1);
            return;
        end
        s_valid = 1'b1;
        s_data  = DW'(x);
        @(posedge clk); #1;
        s_valid = 1'b0;
        push_model(x);
    endtask

    task automatic get_output(input int hold, input bit early,
                              output logic signed [63:0] y);
        int t = 0;
        y = 0;
        m_ready = early;
        while (!m_valid && t < 300) begin
            @(posedge clk); #1; t++;
        end
        if (!m_valid) begin
            check("m_valid_timeout", m_valid, 1);
            m_ready = 1'b0;
            return;
        end
        y = $signed(m_data);
        if (hold > 0) begin
            m_ready = 1'b0;
            repeat (hold) begin
                @(posedge clk); #1;
            end
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
    endtask

    task automatic run_and_check(input string name, input int x,
                                 input int hold, input bit early);
        logic signed [63:0] y;
        send_sample(x);
        get_output(hold, early, y);
        check(name, y, model_y());
    endtask

    initial begin
        #2_000_000;
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic signed [63:0] y;
        logic [ACC_W-1:0]   held;
        int addr_err, busy_cnt, stable_err, c;

        for (int i = 0; i < NTAPS; i++) coef[i] = i + 10;
        for (int n = 0; n < 75; n++) begin
            vec[n].sample   = (n == 0) ? 127 : 0;
            vec[n].expected = (n < NTAPS) ? 127 * (n + 10) : 0;
        end

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_s_ready", s_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", $signed(m_data), 0);
        check("rst_coeff_addr", coeff_addr, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Impulse table
        for (int n = 0; n < 75; n++) begin
            send_sample(vec[n].sample);
            get_output(0, 1'b1, y);
            check($sformatf("impulse[%0d]", n), y, vec[n].expected);
        end

        // Latency and addressing
        send_sample(55);
        addr_err = 0;
        busy_cnt = 0;
        for (int j = 0; j < NTAPS; j++) begin
            if (coeff_addr !== AW'(j)) addr_err++;
            if (m_valid !== 1'b0) addr_err++;
            if (busy) busy_cnt++;
            @(posedge clk); #1;
        end
        if (busy) busy_cnt++;
        check("lat_m_valid_in_drain", m_valid, 0);
        @(posedge clk); #1;
        check("lat_addr_seq_errors", addr_err, 0);
        check("lat_busy_cycles", busy_cnt, 72);
        check("lat_m_valid_at_72", m_valid, 1);
        check("lat_busy_in_out", busy, 0);
        check("lat_s_ready_in_out", s_ready, 0);
        get_output(0, 1'b0, y);
        check("lat_value", y, model_y());

        // Backpressure with ignored s_valid pulses
        send_sample(-77);
        c = 0;
        while (!m_valid && c < 300) begin
            @(posedge clk); #1; c++;
        end
        check("bp_m_valid", m_valid, 1);
        held = m_data;
        stable_err = 0;
        for (int j = 0; j < 20; j++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = DW'($urandom_range(0, 255));
            @(posedge clk); #1;
            if (!m_valid || m_data !== held || s_ready) stable_err++;
        end
        s_valid = 1'b0;
        check("bp_stable_errors", stable_err, 0);
        check("bp_value", $signed(held), model_y());
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("bp_m_valid_drop", m_valid, 0);
        check("bp_s_ready_back", s_ready, 1);
        run_and_check("bp_next_sample", 33, 0, 1'b0);

        // Throughput with m_ready and s_valid held high
        send_sample(21);
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = DW'(-9);
        c = 0;
        y = 0;
        while (!s_ready && c < 200) begin
            @(posedge clk); #1; c++;
            if (m_valid) y = $signed(m_data);
        end
        check("tp_value", y, model_y());
        check("tp_idle_gap", c, 73);
        @(posedge clk); #1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        push_model(-9);
        get_output(0, 1'b0, y);
        check("tp_second_value", y, model_y());

        // Async reset mid-MAC
        send_sample(99);
        repeat (30) begin
            @(posedge clk); #1;
        end
        check("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_s_ready", s_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_m_data", $signed(m_data), 0);
        check("mid_rst_coeff_addr", coeff_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hist.delete();
        @(posedge clk); #1;

        // Async reset in OUT
        send_sample(50);
        c = 0;
        while (!m_valid && c < 300) begin
            @(posedge clk); #1; c++;
        end
        check("out_m_valid_before", m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("out_rst_m_valid", m_valid, 0);
        check("out_rst_m_data", $signed(m_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hist.delete();
        @(posedge clk); #1;
        run_and_check("post_rst_clean_history", 13, 0, 1'b0);

        // Full scale negative
        apply_reset();
        for (int i = 0; i < NTAPS; i++) coef[i] = -128;
        for (int n = 0; n < NTAPS; n++) begin
            send_sample(-128);
            get_output(0, 1'b1, y);
            check($sformatf("fs_neg[%0d]", n), y, longint'(n + 1) * 16384);
        end
        check("fs_neg_final", y, 1163264);

        // Full scale mixed sign
        apply_reset();
        for (int i = 0; i < NTAPS; i++) coef[i] = 127;
        for (int n = 0; n < NTAPS; n++) begin
            send_sample(-128);
            get_output(0, 1'b1, y);
            if (n % 10 == 0) check($sformatf("fs_mix[%0d]", n), y, longint'(n + 1) * -16256);
        end
        check("fs_mix_final", y, -1154176);

        // Random data, random coefficients and random backpressure
        apply_reset();
        for (int i = 0; i < NTAPS; i++) coef[i] = int'($urandom_range(0, 255)) - 128;
        for (int n = 0; n < 200; n++) begin
            run_and_check($sformatf("rand[%0d]", n), int'($urandom_range(0, 255)) - 128,
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
